// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit:
// operation encodings, carry-lookahead group width, flag-vector layout and
// the 4-bit group propagate/generate helper.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int GROUP_W = 4;

  // Bit positions inside the registered flag vector
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef logic [3:0] flags_t;

  // Group propagate/generate of one 4-bit group, returned as {P, G}
  function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                          input logic [GROUP_W-1:0] g);
    logic grp_p;
    logic grp_g;
    grp_p = &p;
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    return {grp_p, grp_g};
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_lcu.sv
// lookahead_carry_unit: purely combinational carry-lookahead over N group
// propagate/generate pairs. Every group carry-in is a flat sum of products
// of the lower groups' p/g and the block carry-in, so no carry ripples
// between groups. Also produces block propagate/generate.
module lookahead_carry_unit #(
  parameter int N = 4
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         cin,
  output logic [N-1:0] c,
  output logic         bp,
  output logic         bg
);

  // Expand c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin for every group
  always_comb begin
    logic run_p;
    logic acc;
    // NOTE: every combinational output gets a default before the loops so no
    // path leaves it unassigned, which would otherwise infer a latch.
    c     = '0;
    run_p = 1'b1;
    acc   = 1'b0;
    for (int i = 0; i < N; i++) begin
      run_p = 1'b1;
      acc   = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        acc   = acc | (run_p & g[j]);
        run_p = run_p & p[j];
      end
      c[i] = acc | (run_p & cin);
    end
  end

  // Block-level propagate and generate across all N groups
  always_comb begin
    logic run_p;
    bp    = &p;
    bg    = 1'b0;
    run_p = 1'b1;
    for (int j = N - 1; j >= 0; j--) begin
      bg    = bg | (run_p & g[j]);
      run_p = run_p & p[j];
    end
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage valid/ready add/subtract unit built from 4-bit
// carry-lookahead groups plus one lookahead carry unit for the inter-group
// carries. S1 registers the operands (B pre-inverted for subtract), S2 does
// the lookahead addition and registers result and C/V/Z/N flags.
// Optional build macro CLA_ADDSUB_SAT_EN adds the in_sat port: a beat with
// in_sat = 1 that overflows clamps to the most positive/negative value.
// WIDTH must be a multiple of 4 in the range 4..64.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
`ifdef CLA_ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NG = WIDTH / GROUP_W;

  // Stage 1 registers. The carry-in equals the op bit (A - B = A + ~B + 1),
  // so the registered op serves as both.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_op;
`ifdef CLA_ADDSUB_SAT_EN
  logic             s1_sat;
`endif

  // Stage 2 (output) registers
  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  flags_t           s2_flags;

  logic s1_adv;
  logic s2_adv;
  logic in_fire;

  // Stage 2 combinational datapath
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_c;
  logic             blk_p;
  logic             blk_g;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;

  // Pipeline advance: a stage moves when it is empty or its successor moves
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && in_ready;

  // S1: capture operands and pre-invert B for subtraction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples its inputs from before the clock edge, independent of
      // statement order.
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
`ifdef CLA_ADDSUB_SAT_EN
      s1_sat   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_a  <= in_a;
        s1_b  <= (in_op == OP_SUB) ? ~in_b : in_b;
        s1_op <= in_op;
`ifdef CLA_ADDSUB_SAT_EN
        s1_sat <= in_sat;
`endif
      end
    end
  end

  // Per-bit generate/propagate and per-group p/g
  assign gen  = s1_a & s1_b;
  assign prop = s1_a ^ s1_b;

  // Reduce each 4-bit slice to its group propagate/generate pair
  always_comb begin
    logic [1:0] pg;
    grp_p = '0;
    grp_g = '0;
    pg    = '0;
    for (int k = 0; k < NG; k++) begin
      pg       = group_pg(prop[k*GROUP_W +: GROUP_W], gen[k*GROUP_W +: GROUP_W]);
      grp_p[k] = pg[1];
      grp_g[k] = pg[0];
    end
  end

  lookahead_carry_unit #(
    .N (NG)
  ) u_lcu (
    .p   (grp_p),
    .g   (grp_g),
    .cin (s1_op),
    .c   (grp_c),
    .bp  (blk_p),
    .bg  (blk_g)
  );

  // In-group lookahead from each group's carry-in, then the sum bits
  always_comb begin
    logic run_p;
    logic acc;
    bit_c   = '0;
    raw_sum = '0;
    run_p   = 1'b1;
    acc     = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP_W; j++) begin
        run_p = 1'b1;
        acc   = 1'b0;
        for (int m = j - 1; m >= 0; m--) begin
          acc   = acc | (run_p & gen[k*GROUP_W + m]);
          run_p = run_p & prop[k*GROUP_W + m];
        end
        bit_c[k*GROUP_W + j]   = acc | (run_p & grp_c[k]);
        raw_sum[k*GROUP_W + j] = prop[k*GROUP_W + j] ^ bit_c[k*GROUP_W + j];
      end
    end
  end

  assign cout = blk_g | (blk_p & s1_op);
  assign ovf  = bit_c[WIDTH-1] ^ cout;

  // Final result: wrap, or clamp on overflow when the beat asked to saturate
  always_comb begin
    res = raw_sum;
`ifdef CLA_ADDSUB_SAT_EN
    // A wrapped negative-looking result means positive overflow and vice versa
    if (s1_sat && ovf) begin
      res = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // S2: register result and flags; held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum           <= res;
        s2_flags[FLAG_C] <= cout;
        s2_flags[FLAG_V] <= ovf;
        s2_flags[FLAG_Z] <= ~|res;
        s2_flags[FLAG_N] <= res[WIDTH-1];
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_sum   = s2_sum;
  assign out_c     = s2_flags[FLAG_C];
  assign out_v     = s2_flags[FLAG_V];
  assign out_z     = s2_flags[FLAG_Z];
  assign out_n     = s2_flags[FLAG_N];

endmodule
